warp_issue_select: RTL and testbench

//  Per-warp instruction buffers plus round-robin warp selector, directly upstream of ScoreBoard.

---
 rtl/warp_issue_select_pkg.sv | 34 +++
 rtl/warp_issue_select_if.sv | 34 +++
 rtl/warp_issue_select_ibuf.sv | 71 +++++++
 rtl/warp_issue_select.sv | 126 ++++++++++++
 tb/tb_warp_issue_select.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/warp_issue_select_pkg.sv
// Shared widths and types for the warp instruction buffers and issue selector.
// The packet width mirrors the decoded packet consumed by ScoreBoard.
package warp_issue_select_pkg;

    localparam int NUM_WARP       = 8;
    localparam int NUM_WARP_LOG   = 3;
    localparam int IBUF_DEPTH     = 2;

    localparam int LDST_SPACE_LOG = 2;
    localparam int INST_TYPES_LOG = 3;
    localparam int SIZE_IMMEDIATE = 16;
    localparam int SIZE_REGFILE   = 8;
    localparam int SIZE_OPCODE    = 6;
    localparam int SIZE_RP        = 4;
    localparam int SIZE_PC        = 32;

    localparam int PKT_W = LDST_SPACE_LOG + 6 + INST_TYPES_LOG + SIZE_IMMEDIATE
                         + 4 * (SIZE_REGFILE + 1) + SIZE_OPCODE + SIZE_RP + 1 + 3 * SIZE_PC;

    typedef logic [NUM_WARP_LOG-1:0] warp_t;
    typedef logic [PKT_W-1:0]        packet_t;

    typedef struct packed {
        logic    valid;
        warp_t   warp;
        packet_t packet;
    } issue_t;

    // Round-robin successor; relies on NUM_WARP being a power of two.
    function automatic warp_t nextWarp(input warp_t w);
        return warp_t'(w + 1'b1);
    endfunction

endpackage

// File: rtl/warp_issue_select_if.sv
// Bundle between fetch/decode + ScoreBoard and the warp issue selector.
// master: upstream/ScoreBoard side; slave: warp_issue_select.
interface warp_issue_select_if
    import warp_issue_select_pkg::*;
();
    logic                stall_i;
    logic                fetchValid_i;
    warp_t               fetchWarp_i;
    packet_t             fetchPacket_i;
    logic [NUM_WARP-1:0] ibufFull_o;
    logic                flushValid_i;
    warp_t               flushWarp_i;
    logic                toSelectPacketValid_o;
    warp_t               toSelectWarp_o;
    packet_t             toSelectPacket_o;
    logic                toSelectReady_i;
    logic                issueValid_o;
    warp_t               issueWarp_o;
    packet_t             issuePacket_o;

    modport master (
        output stall_i, fetchValid_i, fetchWarp_i, fetchPacket_i,
        output flushValid_i, flushWarp_i, toSelectReady_i,
        input  ibufFull_o, toSelectPacketValid_o, toSelectWarp_o, toSelectPacket_o,
        input  issueValid_o, issueWarp_o, issuePacket_o
    );

    modport slave (
        input  stall_i, fetchValid_i, fetchWarp_i, fetchPacket_i,
        input  flushValid_i, flushWarp_i, toSelectReady_i,
        output ibufFull_o, toSelectPacketValid_o, toSelectWarp_o, toSelectPacket_o,
        output issueValid_o, issueWarp_o, issuePacket_o
    );
endinterface

// File: rtl/warp_issue_select_ibuf.sv
// warp_ibuf: one small per-warp FIFO with push, pop, flush and a combinational head.
// Flush wins over push/pop; a push into a full buffer is accepted only alongside a pop.
module warp_ibuf
    import warp_issue_select_pkg::*;
#(
    parameter int DEPTH = IBUF_DEPTH,
    parameter int WIDTH = PKT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pushEn,
    input  logic             popEn,
    input  logic             flushEn,
    input  logic [WIDTH-1:0] pushData,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;
    logic             pushOk;
    logic             popOk;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign headData = mem[rdPtr];

    // Full is the registered state, so fetch still sees full during a push+pop cycle.
    assign pushOk = pushEn && (!full || popEn) && !flushEn;
    assign popOk  = popEn && !empty && !flushEn;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flushEn) begin
            rdPtr <= wrPtr;
            count <= '0;
        end else begin
            if (pushOk) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + PTR_W'(1);
            end
            if (popOk) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({pushOk, popOk})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            pushIntoFull: assert (!(pushEn && full && !popEn && !flushEn))
                else $warning("warp_ibuf: push into full buffer dropped");
        end
    end

endmodule

// File: rtl/warp_issue_select.sv
// Per-warp instruction buffers plus round-robin candidate selection toward ScoreBoard.
// Optional ISSUE_PERF_CNT_EN adds saturating issue/block performance counters.
module warp_issue_select
    import warp_issue_select_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    warp_issue_select_if.slave       ifc
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]              perfIssueCnt_o,
    output logic [31:0]              perfBlockCnt_o
`endif
);
    logic [NUM_WARP-1:0] pushVec;
    logic [NUM_WARP-1:0] popVec;
    logic [NUM_WARP-1:0] flushVec;
    logic [NUM_WARP-1:0] fullVec;
    logic [NUM_WARP-1:0] emptyVec;
    logic [NUM_WARP-1:0] eligible;
    packet_t             headVec [NUM_WARP];

    warp_t   rrPtr;
    logic    candValid;
    warp_t   candWarp;
    warp_t   scanIdx;
    packet_t candPacket;
    logic    fire;
    logic    blocked;
    issue_t  issueReg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WARP; gi++) begin : gWarp
            assign pushVec[gi]  = ifc.fetchValid_i && (ifc.fetchWarp_i == warp_t'(gi));
            assign flushVec[gi] = ifc.flushValid_i && (ifc.flushWarp_i == warp_t'(gi));
            assign popVec[gi]   = fire && (candWarp == warp_t'(gi));
            // A warp being flushed this cycle must not be offered to ScoreBoard.
            assign eligible[gi] = !emptyVec[gi] && !flushVec[gi];

            warp_ibuf #(
                .DEPTH (IBUF_DEPTH),
                .WIDTH (PKT_W)
            ) uIbuf (
                .clk      (clk),
                .reset    (reset),
                .pushEn   (pushVec[gi]),
                .popEn    (popVec[gi]),
                .flushEn  (flushVec[gi]),
                .pushData (ifc.fetchPacket_i),
                .headData (headVec[gi]),
                .full     (fullVec[gi]),
                .empty    (emptyVec[gi])
            );
        end
    endgenerate

    // Descending scan so the warp closest to rrPtr is the last (winning) assignment.
    always_comb begin
        candValid = 1'b0;
        candWarp  = rrPtr;
        scanIdx   = rrPtr;
        for (int i = NUM_WARP - 1; i >= 0; i--) begin
            scanIdx = rrPtr + warp_t'(i);
            if (eligible[scanIdx]) begin
                candValid = 1'b1;
                candWarp  = scanIdx;
            end
        end
    end

    assign candPacket = headVec[candWarp];
    assign fire       = candValid && ifc.toSelectReady_i && !ifc.stall_i;
    assign blocked    = candValid && !ifc.toSelectReady_i && !ifc.stall_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rrPtr    <= '0;
            issueReg <= '0;
        end else if (!ifc.stall_i) begin
            issueReg.valid <= fire;
            if (fire) begin
                issueReg.warp   <= candWarp;
                issueReg.packet <= candPacket;
            end
            // Advancing past a blocked warp keeps it from starving the others.
            if (candValid) begin
                rrPtr <= nextWarp(candWarp);
            end
        end
    end

    assign ifc.ibufFull_o            = fullVec;
    assign ifc.toSelectPacketValid_o = candValid;
    assign ifc.toSelectWarp_o        = candWarp;
    assign ifc.toSelectPacket_o      = candPacket;
    assign ifc.issueValid_o          = issueReg.valid;
    assign ifc.issueWarp_o           = issueReg.warp;
    assign ifc.issuePacket_o         = issueReg.packet;

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] issueCnt;
    logic [31:0] blockCnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issueCnt <= '0;
            blockCnt <= '0;
        end else begin
            if (fire && (issueCnt != '1)) begin
                issueCnt <= issueCnt + 32'd1;
            end
            if (blocked && (blockCnt != '1)) begin
                blockCnt <= blockCnt + 32'd1;
            end
        end
    end

    assign perfIssueCnt_o = issueCnt;
    assign perfBlockCnt_o = blockCnt;
`else
    logic unusedBlocked;
    assign unusedBlocked = blocked;
`endif

endmodule

// File: tb/tb_warp_issue_select.sv
// Directed self-checking bench for warp_issue_select: latency, round-robin order,
// blocked-warp fairness, full/drop behaviour, flush, stall hold and async reset.
module tb_warp_issue_select;
    import warp_issue_select_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    warp_issue_select_if ifc ();

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] perfIssueCnt;
    logic [31:0] perfBlockCnt;
`endif

    warp_issue_select dut (
        .clk   (clk),
        .reset (reset),
        .ifc   (ifc)
`ifdef ISSUE_PERF_CNT_EN
        ,
        .perfIssueCnt_o (perfIssueCnt),
        .perfBlockCnt_o (perfBlockCnt)
`endif
    );

    function automatic packet_t mkPkt(input int w, input int k);
        packet_t p;
        p = '0;
        p[PKT_W-1 -: 8] = 8'hA5;
        p[15:0] = 16'(w * 256 + k + 16);
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push(input int w, input packet_t p);
        ifc.fetchValid_i  = 1'b1;
        ifc.fetchWarp_i   = warp_t'(w);
        ifc.fetchPacket_i = p;
        tick();
        ifc.fetchValid_i  = 1'b0;
        $display("push warp=%0d pkt=%h", w, p);
    endtask

    task automatic test_reset();
        ifc.stall_i = 1'b0; ifc.fetchValid_i = 1'b0; ifc.fetchWarp_i = '0; ifc.fetchPacket_i = '0;
        ifc.flushValid_i = 1'b0; ifc.flushWarp_i = '0; ifc.toSelectReady_i = 1'b0;
        reset = 1'b0;
        tick(); tick();
        checks++; if (ifc.issueValid_o !== 1'b0) begin errors++; $display("FAIL reset_issueValid got=%b exp=0", ifc.issueValid_o); end
        checks++; if (ifc.issueWarp_o !== 3'd0) begin errors++; $display("FAIL reset_issueWarp got=%0d exp=0", ifc.issueWarp_o); end
        checks++; if (ifc.issuePacket_o !== '0) begin errors++; $display("FAIL reset_issuePacket got=%h exp=0", ifc.issuePacket_o); end
        checks++; if (ifc.ibufFull_o !== 8'h00) begin errors++; $display("FAIL reset_ibufFull got=%h exp=00", ifc.ibufFull_o); end
        checks++; if (ifc.toSelectPacketValid_o !== 1'b0) begin errors++; $display("FAIL reset_candValid got=%b exp=0", ifc.toSelectPacketValid_o); end
        reset = 1'b1;
        $display("reset released");
    endtask

    task automatic test_single_issue();
        packet_t a;
        a = mkPkt(3, 0);
        ifc.toSelectReady_i = 1'b1;
        push(3, a);
        settle();
        checks++; if ({ifc.toSelectPacketValid_o, ifc.toSelectWarp_o, ifc.toSelectPacket_o} !== {1'b1, 3'd3, a})
            begin errors++; $display("FAIL single_cand got=%b/%0d/%h exp=1/3/%h", ifc.toSelectPacketValid_o, ifc.toSelectWarp_o, ifc.toSelectPacket_o, a); end
        checks++; if (ifc.issueValid_o !== 1'b0) begin errors++; $display("FAIL single_early_issue got=%b exp=0", ifc.issueValid_o); end
        tick();
        checks++; if ({ifc.issueValid_o, ifc.issueWarp_o, ifc.issuePacket_o} !== {1'b1, 3'd3, a})
            begin errors++; $display("FAIL single_issue got=%b/%0d/%h exp=1/3/%h", ifc.issueValid_o, ifc.issueWarp_o, ifc.issuePacket_o, a); end
        $display("issue warp=%0d pkt=%h", ifc.issueWarp_o, ifc.issuePacket_o);
        checks++; if (ifc.toSelectPacketValid_o !== 1'b0) begin errors++; $display("FAIL single_drained got=%b exp=0", ifc.toSelectPacketValid_o); end
        tick();
        checks++; if (ifc.issueValid_o !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", ifc.issueValid_o); end
    endtask

    task automatic test_round_robin();
        ifc.stall_i = 1'b1;
        ifc.toSelectReady_i = 1'b1;
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 2; k++) begin
                push(w, mkPkt(w, k));
            end
        end
        ifc.stall_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if ({ifc.issueValid_o, ifc.issueWarp_o, ifc.issuePacket_o} !== {1'b1, warp_t'(i % 3), mkPkt(i % 3, i / 3)})
                begin errors++; $display("FAIL rr_issue%0d got=%b/%0d/%h exp=1/%0d/%h", i, ifc.issueValid_o, ifc.issueWarp_o, ifc.issuePacket_o, i % 3, mkPkt(i % 3, i / 3)); end
            $display("issue warp=%0d pkt=%h", ifc.issueWarp_o, ifc.issuePacket_o);
        end
        tick();
        checks++; if ({ifc.issueValid_o, ifc.toSelectPacketValid_o} !== 2'b00)
            begin errors++; $display("FAIL rr_empty got=%b%b exp=00", ifc.issueValid_o, ifc.toSelectPacketValid_o); end
    endtask

    task automatic test_blocked_warp();
        ifc.stall_i = 1'b1;
        push(1, mkPkt(1, 5));
        push(2, mkPkt(2, 5));
        ifc.stall_i = 1'b0;
        ifc.toSelectReady_i = 1'b0;
        settle();
        checks++; if ({ifc.toSelectPacketValid_o, ifc.toSelectWarp_o} !== {1'b1, 3'd1})
            begin errors++; $display("FAIL blk_cand1 got=%b/%0d exp=1/1", ifc.toSelectPacketValid_o, ifc.toSelectWarp_o); end
        tick();
        checks++; if (ifc.issueValid_o !== 1'b0) begin errors++; $display("FAIL blk_noissue got=%b exp=0", ifc.issueValid_o); end
        ifc.toSelectReady_i = 1'b1;
        settle();
        checks++; if ({ifc.toSelectPacketValid_o, ifc.toSelectWarp_o} !== {1'b1, 3'd2})
            begin errors++; $display("FAIL blk_cand2 got=%b/%0d exp=1/2", ifc.toSelectPacketValid_o, ifc.toSelectWarp_o); end
        tick();
        checks++; if ({ifc.issueValid_o, ifc.issueWarp_o, ifc.issuePacket_o} !== {1'b1, 3'd2, mkPkt(2, 5)})
            begin errors++; $display("FAIL blk_issue2 got=%b/%0d/%h exp=1/2/%h", ifc.issueValid_o, ifc.issueWarp_o, ifc.issuePacket_o, mkPkt(2, 5)); end
        $display("issue warp=%0d pkt=%h", ifc.issueWarp_o, ifc.issuePacket_o);
        tick();
        checks++; if ({ifc.issueValid_o, ifc.issueWarp_o, ifc.issuePacket_o} !== {1'b1, 3'd1, mkPkt(1, 5)})
            begin errors++; $display("FAIL blk_retry1 got=%b/%0d/%h exp=1/1/%h", ifc.issueValid_o, ifc.issueWarp_o, ifc.issuePacket_o, mkPkt(1, 5)); end
        $display("issue warp=%0d pkt=%h", ifc.issueWarp_o, ifc.issuePacket_o);
        tick();
    endtask

    task automatic test_full_push_pop();
        ifc.stall_i = 1'b1;
        ifc.toSelectReady_i = 1'b0;
        push(5, mkPkt(5, 0));
        push(5, mkPkt(5, 1));
        checks++; if (ifc.ibufFull_o !== 8'h20) begin errors++; $display("FAIL full_set got=%h exp=20", ifc.ibufFull_o); end
        push(5, mkPkt(5, 2));
        checks++; if (ifc.ibufFull_o !== 8'h20) begin errors++; $display("FAIL full_drop got=%h exp=20", ifc.ibufFull_o); end
        ifc.fetchValid_i = 1'b1; ifc.fetchWarp_i = 3'd5; ifc.fetchPacket_i = mkPkt(5, 3);
        ifc.stall_i = 1'b0;
        ifc.toSelectReady_i = 1'b1;
        settle();
        checks++; if ({ifc.toSelectPacketValid_o, ifc.toSelectWarp_o, ifc.toSelectPacket_o} !== {1'b1, 3'd5, mkPkt(5, 0)})
            begin errors++; $display("FAIL full_cand got=%b/%0d/%h exp=1/5/%h", ifc.toSelectPacketValid_o, ifc.toSelectWarp_o, ifc.toSelectPacket_o, mkPkt(5, 0)); end
        tick();
        ifc.fetchValid_i = 1'b0;
        checks++; if (ifc.ibufFull_o !== 8'h20) begin errors++; $display("FAIL full_pushpop_count got=%h exp=20", ifc.ibufFull_o); end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            checks++; if ({ifc.issueValid_o, ifc.issueWarp_o, ifc.issuePacket_o} !== {1'b1, 3'd5, mkPkt(5, (k == 2) ? 3 : k)})
                begin errors++; $display("FAIL full_issue%0d got=%b/%0d/%h exp=1/5/%h", k, ifc.issueValid_o, ifc.issueWarp_o, ifc.issuePacket_o, mkPkt(5, (k == 2) ? 3 : k)); end
            $display("issue warp=%0d pkt=%h", ifc.issueWarp_o, ifc.issuePacket_o);
        end
        checks++; if (ifc.ibufFull_o !== 8'h00) begin errors++; $display("FAIL full_cleared got=%h exp=00", ifc.ibufFull_o); end
        tick();
        checks++; if (ifc.issueValid_o !== 1'b0) begin errors++; $display("FAIL full_idle got=%b exp=0", ifc.issueValid_o); end
    endtask

    task automatic test_flush();
        ifc.stall_i = 1'b1;
        ifc.toSelectReady_i = 1'b1;
        push(4, mkPkt(4, 0));
        push(4, mkPkt(4, 1));
        checks++; if (ifc.ibufFull_o !== 8'h10) begin errors++; $display("FAIL flush_full got=%h exp=10", ifc.ibufFull_o); end
        ifc.flushValid_i = 1'b1; ifc.flushWarp_i = 3'd4;
        ifc.fetchValid_i = 1'b1; ifc.fetchWarp_i = 3'd4; ifc.fetchPacket_i = mkPkt(4, 2);
        settle();
        checks++; if (ifc.toSelectPacketValid_o !== 1'b0) begin errors++; $display("FAIL flush_mask got=%b exp=0", ifc.toSelectPacketValid_o); end
        tick();
        ifc.flushValid_i = 1'b0; ifc.fetchValid_i = 1'b0; ifc.stall_i = 1'b0;
        settle();
        $display("flush warp=4");
        checks++; if (ifc.ibufFull_o !== 8'h00) begin errors++; $display("FAIL flush_empty got=%h exp=00", ifc.ibufFull_o); end
        checks++; if (ifc.toSelectPacketValid_o !== 1'b0) begin errors++; $display("FAIL flush_nocand got=%b exp=0", ifc.toSelectPacketValid_o); end
        tick();
        checks++; if (ifc.issueValid_o !== 1'b0) begin errors++; $display("FAIL flush_noissue got=%b exp=0", ifc.issueValid_o); end
    endtask

    task automatic test_stall_and_reset();
        ifc.stall_i = 1'b1;
        ifc.toSelectReady_i = 1'b1;
        push(6, mkPkt(6, 0));
        push(7, mkPkt(7, 1));
        ifc.stall_i = 1'b0;
        tick();
        checks++; if ({ifc.issueValid_o, ifc.issueWarp_o, ifc.issuePacket_o} !== {1'b1, 3'd6, mkPkt(6, 0)})
            begin errors++; $display("FAIL stall_pre got=%b/%0d/%h exp=1/6/%h", ifc.issueValid_o, ifc.issueWarp_o, ifc.issuePacket_o, mkPkt(6, 0)); end
        ifc.stall_i = 1'b1;
        ifc.fetchValid_i = 1'b1; ifc.fetchWarp_i = 3'd0; ifc.fetchPacket_i = mkPkt(0, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            ifc.fetchValid_i = 1'b0;
            settle();
            checks++; if ({ifc.issueValid_o, ifc.issueWarp_o, ifc.issuePacket_o} !== {1'b1, 3'd6, mkPkt(6, 0)})
                begin errors++; $display("FAIL stall_hold%0d got=%b/%0d/%h exp=1/6/%h", i, ifc.issueValid_o, ifc.issueWarp_o, ifc.issuePacket_o, mkPkt(6, 0)); end
            checks++; if ({ifc.toSelectPacketValid_o, ifc.toSelectWarp_o, ifc.toSelectPacket_o} !== {1'b1, 3'd7, mkPkt(7, 1)})
                begin errors++; $display("FAIL stall_cand%0d got=%b/%0d/%h exp=1/7/%h", i, ifc.toSelectPacketValid_o, ifc.toSelectWarp_o, ifc.toSelectPacket_o, mkPkt(7, 1)); end
        end
        ifc.stall_i = 1'b0;
        tick();
        checks++; if ({ifc.issueValid_o, ifc.issueWarp_o, ifc.issuePacket_o} !== {1'b1, 3'd7, mkPkt(7, 1)})
            begin errors++; $display("FAIL stall_release got=%b/%0d/%h exp=1/7/%h", ifc.issueValid_o, ifc.issueWarp_o, ifc.issuePacket_o, mkPkt(7, 1)); end
        $display("issue warp=%0d pkt=%h", ifc.issueWarp_o, ifc.issuePacket_o);
        checks++; if ({ifc.toSelectPacketValid_o, ifc.toSelectWarp_o} !== {1'b1, 3'd0})
            begin errors++; $display("FAIL stall_pending got=%b/%0d exp=1/0", ifc.toSelectPacketValid_o, ifc.toSelectWarp_o); end
        #2;
        reset = 1'b0;
        #1;
        $display("async reset asserted");
        checks++; if ({ifc.issueValid_o, ifc.issueWarp_o, ifc.issuePacket_o} !== {1'b0, 3'd0, packet_t'(0)})
            begin errors++; $display("FAIL midreset_issue got=%b/%0d/%h exp=0/0/0", ifc.issueValid_o, ifc.issueWarp_o, ifc.issuePacket_o); end
        checks++; if ({ifc.toSelectPacketValid_o, ifc.ibufFull_o} !== 9'h000)
            begin errors++; $display("FAIL midreset_cand got=%b/%h exp=0/00", ifc.toSelectPacketValid_o, ifc.ibufFull_o); end
        tick();
        reset = 1'b1;
        tick();
        checks++; if ({ifc.issueValid_o, ifc.toSelectPacketValid_o} !== 2'b00)
            begin errors++; $display("FAIL postreset_lost got=%b%b exp=00", ifc.issueValid_o, ifc.toSelectPacketValid_o); end
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_round_robin();
        test_blocked_warp();
        test_full_push_pop();
        test_flush();
        test_stall_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
